// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of the five-stage pipeline.
//
// Takes the ALU result from execute as either a load/store address or a
// pass-through value. Drives a single-outstanding req/ack data-memory port,
// steers byte/halfword lanes, sign/zero-extends loads and emits one registered
// writeback beat per accepted instruction.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     upstream handshake; o_ready is high only in IDLE
//   i_alu_result          effective address or pass-through result
//   i_store_data          store source (rt)
//   i_mem_read/i_mem_write load / store (store wins if both set)
//   i_size, i_unsigned    access size (00 B, 01 H, 1x W) and load extension
//   i_rd, i_reg_write     destination register and its write enable
//   o_dmem_*              request side of the data-memory port
//   i_dmem_ack/rdata      completion and read data (same cycle)
//   o_wb_*                one-cycle registered writeback beat
//   o_misaligned          address-error flag, qualified by o_wb_valid
module mem_access_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [4:0]       i_rd,
  input  logic             i_reg_write,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_rd,
  output logic             o_wb_reg_write,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_misaligned
);

  typedef enum logic {StIdle, StAccess} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  state_e state_q, state_d;

  // Request-side registers
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  // Context of the access in flight, used to build the writeback beat
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_reg_write_q, pend_reg_write_d;
  logic             pend_store_q, pend_store_d;
  logic [1:0]       pend_size_q, pend_size_d;
  logic             pend_unsigned_q, pend_unsigned_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;

  // Writeback registers
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             misaligned_q, misaligned_d;

  logic             accept;
  logic             is_store;
  logic             is_load;
  logic             misaligned;
  logic [1:0]       lane;
  logic [3:0]       lane_be;
  logic [WIDTH-1:0] lane_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] load_data;

  assign o_ready = (state_q == StIdle);
  assign accept  = i_valid && o_ready;
  assign is_store = i_mem_write;
  // Store wins when both flags are set
  assign is_load  = i_mem_read && !i_mem_write;
  assign lane     = i_alu_result[1:0];

  // Alignment check and lane steering for the incoming instruction
  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'b1111;
    lane_wdata = i_store_data;
    if (i_size == SizeByte) begin
      lane_be    = 4'b0001 << lane;
      lane_wdata = {4{i_store_data[7:0]}};
    end else if (i_size == SizeHalf) begin
      misaligned = lane[0];
      lane_be    = lane[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{i_store_data[15:0]}};
    end else begin
      // 10 and 11 are both word accesses
      misaligned = (lane != 2'b00);
    end
  end

  // Load extraction from the returned word using the pending access context
  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = pend_addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    load_data = i_dmem_rdata;
    unique case (pend_addr_q[1:0])
      2'b00: ld_byte = i_dmem_rdata[7:0];
      2'b01: ld_byte = i_dmem_rdata[15:8];
      2'b10: ld_byte = i_dmem_rdata[23:16];
      2'b11: ld_byte = i_dmem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    if (pend_size_q == SizeByte) begin
      load_data = {{24{ld_byte[7] & ~pend_unsigned_q}}, ld_byte};
    end else if (pend_size_q == SizeHalf) begin
      load_data = {{16{ld_half[15] & ~pend_unsigned_q}}, ld_half};
    end
  end

  // Next-state logic
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    pend_rd_d        = pend_rd_q;
    pend_reg_write_d = pend_reg_write_q;
    pend_store_d     = pend_store_q;
    pend_size_d      = pend_size_q;
    pend_unsigned_d  = pend_unsigned_q;
    pend_addr_d      = pend_addr_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_reg_write_d   = wb_reg_write_q;
    wb_data_d        = wb_data_q;
    misaligned_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_store && !is_load) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = i_rd;
            wb_reg_write_d = i_reg_write && (i_rd != 5'd0);
            wb_data_d      = i_alu_result;
          end else if (misaligned) begin
            // Address error: no request, flagged beat with no register write
            wb_valid_d     = 1'b1;
            wb_rd_d        = i_rd;
            wb_reg_write_d = 1'b0;
            wb_data_d      = i_alu_result;
            misaligned_d   = 1'b1;
          end else begin
            req_d            = 1'b1;
            we_d             = is_store;
            addr_d           = {i_alu_result[WIDTH-1:2], 2'b00};
            wdata_d          = lane_wdata;
            be_d             = lane_be;
            pend_rd_d        = i_rd;
            pend_reg_write_d = is_load && i_reg_write && (i_rd != 5'd0);
            pend_store_d     = is_store;
            pend_size_d      = i_size;
            pend_unsigned_d  = i_unsigned;
            pend_addr_d      = i_alu_result;
            state_d          = StAccess;
          end
        end
      end
      StAccess: begin
        if (i_dmem_ack) begin
          req_d          = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = pend_rd_q;
          wb_reg_write_d = pend_reg_write_q;
          wb_data_d      = pend_store_q ? pend_addr_q : load_data;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= StIdle;
      req_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      be_q             <= 4'b0000;
      pend_rd_q        <= 5'd0;
      pend_reg_write_q <= 1'b0;
      pend_store_q     <= 1'b0;
      pend_size_q      <= 2'b00;
      pend_unsigned_q  <= 1'b0;
      pend_addr_q      <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_reg_write_q   <= 1'b0;
      wb_data_q        <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      be_q             <= be_d;
      pend_rd_q        <= pend_rd_d;
      pend_reg_write_q <= pend_reg_write_d;
      pend_store_q     <= pend_store_d;
      pend_size_q      <= pend_size_d;
      pend_unsigned_q  <= pend_unsigned_d;
      pend_addr_q      <= pend_addr_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_data_q        <= wb_data_d;
      misaligned_q     <= misaligned_d;
    end
  end

  assign o_dmem_req     = req_q;
  assign o_dmem_we      = we_q;
  assign o_dmem_addr    = addr_q;
  assign o_dmem_wdata   = wdata_q;
  assign o_dmem_be      = be_q;
  assign o_wb_valid     = wb_valid_q;
  assign o_wb_rd        = wb_rd_q;
  assign o_wb_reg_write = wb_reg_write_q;
  assign o_wb_data      = wb_data_q;
  assign o_misaligned   = misaligned_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute-stage ALU. It takes the ALU result as a load/store address or pass-through value and drives a single-outstanding request/acknowledge data-memory port. It performs byte/halfword/word lane steering and load sign/zero extension, and presents one registered writeback beat per accepted instruction. It back-pressures execute while a memory access is in flight.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  execute stage presents an instruction.
- o_ready  out  1  stage accepts the instruction this cycle; transfer occurs when i_valid && o_ready.
- i_alu_result  in  WIDTH  ALU output: effective address for loads/stores, result for all other instructions.
- i_store_data  in  WIDTH  rt value for stores.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- i_unsigned  in  1  zero-extend load (LBU/LHU); otherwise sign-extend.
- i_rd  in  5  destination register.
- i_reg_write  in  1  instruction writes rd.
- o_dmem_req  out  1  memory request; held until acknowledged.
- o_dmem_we  out  1  write request.
- o_dmem_addr  out  WIDTH  word address, {addr[31:2],2'b00}.
- o_dmem_wdata  out  WIDTH  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  memory completes the request this cycle; read data is valid in the same cycle.
- i_dmem_rdata  in  WIDTH  read word.
- o_wb_valid  out  1  one-cycle writeback beat.
- o_wb_rd  out  5  destination register.
- o_wb_reg_write  out  1  write enable to the register file.
- o_wb_data  out  WIDTH  load result or pass-through ALU result.
- o_misaligned  out  1  address-error flag, valid only when o_wb_valid is high.

## Operation
- Two-state FSM, IDLE and ACCESS. o_ready = (state == IDLE).
- IDLE, accepting an instruction with no memory op:
  - Register o_wb_* from the inputs with o_wb_data = i_alu_result.
  - Stay in IDLE.
- IDLE, accepting a memory op: check alignment.
  - Misaligned: half with addr[0]=1, or word/11 with addr[1:0]≠0.
  - A misaligned op issues no request. It emits a wb beat with o_misaligned=1 and o_wb_reg_write=0, and stays in IDLE.
- IDLE, accepting an aligned memory op: register the request fields, set o_dmem_req, and go to ACCESS.
- If i_mem_write and i_mem_read are both set, the store wins and the load is ignored.
- ACCESS: hold o_dmem_req, we, addr, wdata and be stable until i_dmem_ack is sampled high.
  - On ack: clear o_dmem_req, emit the wb beat, return to IDLE.
- i_dmem_ack outside ACCESS is ignored.
- Byte lanes are little-endian, selected by a = addr[1:0].
- Byte enables:
  - Byte: be = 1<<a.
  - Half: be = 0011 (a=0) or 1100 (a=2).
  - Word: be = 1111.
- Store data:
  - Byte: low byte replicated ×4.
  - Half: low half replicated ×2.
  - Word: unchanged.
- Load result:
  - Byte: select byte a.
  - Half: select half a[1].
  - Extend to 32 bits, zero-extended if i_unsigned, sign-extended otherwise.
  - Word: rdata unchanged.
- Store wb beat: o_wb_reg_write=0, o_wb_data = address.
- o_wb_reg_write is forced to 0 when rd = 0.
- Reset: state=IDLE.
  - o_ready=1 after reset.
  - These outputs reset to 0: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_wb_valid, o_wb_rd, o_wb_reg_write, o_wb_data, o_misaligned.
  - Reset during ACCESS abandons the request: o_dmem_req is low the cycle after the reset edge, and no wb beat is produced.

## Timing
- Non-memory op or misaligned op accepted at edge E: o_wb_valid is high in cycle E+1 for exactly one cycle. Back-to-back acceptance every cycle is supported.
- Aligned memory op accepted at edge E: o_dmem_req is high from cycle E+1 through the cycle in which ack is sampled. For ack sampled at edge A, o_wb_valid is high in cycle A+1.
  - Minimum latency is 2 cycles (ack in the first request cycle).
  - o_ready is low from E+1 through the ack cycle and high again in A+1. A new instruction can be accepted at edge A+1.
- o_wb_valid is never high for two consecutive cycles unless consecutive acceptances occurred.
- o_misaligned is a one-cycle pulse, high only together with o_wb_valid.

## Test plan
- ADD pass-through: i_alu_result=0x0000_1234, rd=5, reg_write=1 for 3 consecutive cycles → three consecutive wb beats; data 0x1234, rd 5, o_dmem_req never asserted.
- LB signed: addr 0x0000_0103, rdata 0x80FF_7F01, ack in first request cycle:
  - Request side: be ignored, addr 0x100.
  - wb_data 0xFFFF_FF80, exactly 2 cycles after acceptance.
  - LBU from the same address → 0x0000_0080.
- SH: addr 0x0000_0202, store_data 0xDEAD_BEEF:
  - Request: be=1100, wdata 0xBEEF_BEEF, we=1.
  - Hold ack low for 3 cycles: request fields stable and o_ready=0 throughout.
  - wb beat with reg_write=0.
- Misaligned LW at 0x0000_0006 → no request; wb beat with o_misaligned=1 and reg_write=0 one cycle later.
- LW to rd=0 at 0x10, rdata 0x1111_2222 → wb_data 0x1111_2222 with wb_reg_write=0.
- Reset asserted during ACCESS (ack never given) → o_dmem_req low and o_ready high after the reset edge, no wb beat. A subsequent ADD completes normally.
